// File: rtl/hash_result_scorer.sv
// hash_result_scorer
// Scores each 1024-bit Skein hash, delivered as 16 x 64-bit words, by its
// Hamming distance to a stored target. Keeps the best (lowest) score and its
// nonce, counts completed hashes, and flags framing errors.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   hash_valid_i/hash_ready_o    word handshake (beat = valid & ready)
//   hash_word_i, hash_last_i     hash word (word 0 first), last-word marker
//   nonce_i                      candidate nonce, sampled on the word-0 beat
//   target_we_i/idx_i/word_i     target word write port
//   result_valid_o               one-cycle pulse, score_o/result_nonce_o valid
//   score_o, result_nonce_o      score and nonce of the last completed hash
//   best_score_o, best_nonce_o   lowest score since reset/target write
//   best_update_o                pulses with result_valid_o when best improved
//   hashes_scored_o              completed-hash counter (wraps)
//   protocol_error_o             sticky framing-error flag
//
// Optional build macro HASH_RESULT_SCORER_THRESHOLD_EN adds threshold_i,
// hit_o (sticky, score <= threshold) and hit_nonce_o (first hitting nonce).
//
// state     | meaning
// ST_ACCEPT | ready high, one popcount stage per beat
// ST_DRAIN1 | ready low, accumulator absorbs the word-15 stage
// ST_DRAIN2 | ready low, score/best/counter registered, result pulses next

module hash_result_scorer #(
  parameter int WORD_W  = 64,
  parameter int WORDS   = 16,
  parameter int NONCE_W = 64,
  parameter int SCORE_W = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hash_valid_i,
  output logic               hash_ready_o,
  input  logic [WORD_W-1:0]  hash_word_i,
  input  logic               hash_last_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic               target_we_i,
  input  logic [3:0]         target_idx_i,
  input  logic [WORD_W-1:0]  target_word_i,
  output logic               result_valid_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [NONCE_W-1:0] result_nonce_o,
  output logic [SCORE_W-1:0] best_score_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               best_update_o,
  output logic [31:0]        hashes_scored_o,
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
  input  logic [SCORE_W-1:0] threshold_i,
  output logic               hit_o,
  output logic [NONCE_W-1:0] hit_nonce_o,
`endif
  output logic               protocol_error_o
);

  localparam int STAGE_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_DRAIN1,
    ST_DRAIN2
  } state_t;

  function automatic logic [STAGE_W-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [STAGE_W-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) c = c + STAGE_W'(v[i]);
    return c;
  endfunction

  state_t               r_state;
  logic                 r_ready;
  logic [3:0]           r_idx;
  logic [WORD_W-1:0]    r_target [WORDS];
  logic [STAGE_W-1:0]   r_stage;
  logic                 r_stage_vld;
  logic                 r_stage_first;
  logic [SCORE_W-1:0]   r_acc;
  logic [NONCE_W-1:0]   r_nonce_cur;
  logic                 r_result_valid;
  logic [SCORE_W-1:0]   r_score;
  logic [NONCE_W-1:0]   r_result_nonce;
  logic [SCORE_W-1:0]   r_best_score;
  logic [NONCE_W-1:0]   r_best_nonce;
  logic                 r_best_update;
  logic [31:0]          r_count;
  logic                 r_perr;
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
  logic                 r_hit;
  logic [NONCE_W-1:0]   r_hit_nonce;
`endif

  logic                 w_beat;
  logic                 w_tgt_wr;
  logic [WORD_W-1:0]    w_tgt_sel;
  logic [STAGE_W-1:0]   w_pop;
  logic                 w_idx_last;
  logic                 w_frame_err;

  assign w_beat      = hash_valid_i & r_ready;
  assign w_tgt_wr    = target_we_i & (r_state == ST_ACCEPT) & (r_idx == 4'd0);
  // A write landing with the word-0 beat must be seen by that beat.
  assign w_tgt_sel   = (w_tgt_wr && (target_idx_i == r_idx)) ? target_word_i
                                                              : r_target[r_idx];
  assign w_pop       = popcount(hash_word_i ^ w_tgt_sel);
  assign w_idx_last  = (r_idx == 4'(WORDS - 1));
  assign w_frame_err = w_beat & (hash_last_i != w_idx_last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_ACCEPT;
      r_ready        <= 1'b1;
      r_idx          <= '0;
      for (int i = 0; i < WORDS; i++) r_target[i] <= '0;
      r_stage        <= '0;
      r_stage_vld    <= 1'b0;
      r_stage_first  <= 1'b0;
      r_acc          <= '0;
      r_nonce_cur    <= '0;
      r_result_valid <= 1'b0;
      r_score        <= '0;
      r_result_nonce <= '0;
      r_best_score   <= '1;
      r_best_nonce   <= '0;
      r_best_update  <= 1'b0;
      r_count        <= '0;
      r_perr         <= 1'b0;
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
      r_hit          <= 1'b0;
      r_hit_nonce    <= '0;
`endif
    end else begin
      r_result_valid <= 1'b0;
      r_best_update  <= 1'b0;
      r_stage_vld    <= 1'b0;

      // Stage is folded in one cycle after its beat; word 0 restarts the sum.
      if (r_stage_vld)
        r_acc <= r_stage_first ? SCORE_W'(r_stage) : r_acc + SCORE_W'(r_stage);

      if (w_tgt_wr) begin
        r_target[target_idx_i] <= target_word_i;
        r_best_score           <= '1;
        r_best_nonce           <= '0;
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
        r_hit                  <= 1'b0;
        r_hit_nonce            <= '0;
`endif
      end

      case (r_state)
        ST_ACCEPT: begin
          if (w_beat) begin
            if (w_frame_err) begin
              // Drop the frame; overrides any pending accumulate above.
              r_perr <= 1'b1;
              r_idx  <= '0;
              r_acc  <= '0;
            end else begin
              r_stage       <= w_pop;
              r_stage_vld   <= 1'b1;
              r_stage_first <= (r_idx == 4'd0);
              if (r_idx == 4'd0) r_nonce_cur <= nonce_i;
              if (w_idx_last) begin
                r_idx   <= '0;
                r_ready <= 1'b0;
                r_state <= ST_DRAIN1;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end
          end
        end
        ST_DRAIN1: begin
          r_state <= ST_DRAIN2;
        end
        ST_DRAIN2: begin
          r_score        <= r_acc;
          r_result_nonce <= r_nonce_cur;
          r_result_valid <= 1'b1;
          r_count        <= r_count + 32'd1;
          if (r_acc < r_best_score) begin
            r_best_score  <= r_acc;
            r_best_nonce  <= r_nonce_cur;
            r_best_update <= 1'b1;
          end
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
          if (!r_hit && (r_acc <= threshold_i)) begin
            r_hit       <= 1'b1;
            r_hit_nonce <= r_nonce_cur;
          end
`endif
          r_ready <= 1'b1;
          r_state <= ST_ACCEPT;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_ACCEPT;
        end
      endcase
    end
  end

  assign hash_ready_o     = r_ready;
  assign result_valid_o   = r_result_valid;
  assign score_o          = r_score;
  assign result_nonce_o   = r_result_nonce;
  assign best_score_o     = r_best_score;
  assign best_nonce_o     = r_best_nonce;
  assign best_update_o    = r_best_update;
  assign hashes_scored_o  = r_count;
  assign protocol_error_o = r_perr;
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
  assign hit_o            = r_hit;
  assign hit_nonce_o      = r_hit_nonce;
`endif

endmodule

// File: tb/tb_hash_result_scorer.sv
module tb_hash_result_scorer;
  localparam int WORD_W  = 64;
  localparam int WORDS   = 16;
  localparam int NONCE_W = 64;
  localparam int SCORE_W = 11;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               hash_valid_i;
  logic               hash_ready_o;
  logic [WORD_W-1:0]  hash_word_i;
  logic               hash_last_i;
  logic [NONCE_W-1:0] nonce_i;
  logic               target_we_i;
  logic [3:0]         target_idx_i;
  logic [WORD_W-1:0]  target_word_i;
  logic               result_valid_o;
  logic [SCORE_W-1:0] score_o;
  logic [NONCE_W-1:0] result_nonce_o;
  logic [SCORE_W-1:0] best_score_o;
  logic [NONCE_W-1:0] best_nonce_o;
  logic               best_update_o;
  logic [31:0]        hashes_scored_o;
  logic               protocol_error_o;
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
  logic [SCORE_W-1:0] threshold_i;
  logic               hit_o;
  logic [NONCE_W-1:0] hit_nonce_o;
`endif

  always #5 clk_i = ~clk_i;

  hash_result_scorer #(
    .WORD_W(WORD_W), .WORDS(WORDS), .NONCE_W(NONCE_W), .SCORE_W(SCORE_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .hash_valid_i(hash_valid_i), .hash_ready_o(hash_ready_o),
    .hash_word_i(hash_word_i), .hash_last_i(hash_last_i), .nonce_i(nonce_i),
    .target_we_i(target_we_i), .target_idx_i(target_idx_i),
    .target_word_i(target_word_i),
    .result_valid_o(result_valid_o), .score_o(score_o),
    .result_nonce_o(result_nonce_o), .best_score_o(best_score_o),
    .best_nonce_o(best_nonce_o), .best_update_o(best_update_o),
    .hashes_scored_o(hashes_scored_o),
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
    .threshold_i(threshold_i), .hit_o(hit_o), .hit_nonce_o(hit_nonce_o),
`endif
    .protocol_error_o(protocol_error_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [63:0] hw [16];
  logic [63:0] tgt_model [16];

  // Result monitor: captures every result pulse away from the clock edge.
  int          res_n = 0;
  int          ready_low = 0;
  logic [10:0] res_score [$];
  logic [63:0] res_nonce [$];
  logic        res_bu [$];
  int          res_cyc [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (result_valid_o) begin
        res_score.push_back(score_o);
        res_nonce.push_back(result_nonce_o);
        res_bu.push_back(best_update_o);
        res_cyc.push_back(cyc);
        res_n++;
      end
      if (!hash_ready_o) ready_low++;
    end
  end

  function automatic int exp_score();
    int s = 0;
    for (int i = 0; i < 16; i++) s += $countones(hw[i] ^ tgt_model[i]);
    return s;
  endfunction

  // err_idx: -1 well-formed, 0..15 last asserted on that beat, 16 last never.
  // partial: >0 sends only that many words with last low.
  task automatic send_hash(input logic [63:0] nonce, input int err_idx,
                           input int max_gap, input int wr_at,
                           input logic [3:0] wr_idx, input logic [63:0] wr_word,
                           input int partial);
    int n_words;
    int guard;
    int gap;
    n_words = (partial > 0) ? partial :
              ((err_idx >= 0 && err_idx < 16) ? err_idx + 1 : 16);
    for (int i = 0; i < n_words; i++) begin
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk_i);
        hash_valid_i = 1'b0;
        target_we_i  = 1'b0;
      end
      @(negedge clk_i);
      hash_valid_i  = 1'b1;
      hash_word_i   = hw[i];
      nonce_i       = (i == 0) ? nonce : ~nonce;
      hash_last_i   = (partial > 0) ? 1'b0 : ((err_idx < 0) ? (i == 15) : (i == err_idx));
      target_we_i   = (i == wr_at);
      target_idx_i  = wr_idx;
      target_word_i = wr_word;
      guard = 0;
      while (!hash_ready_o && guard < 20) begin
        @(negedge clk_i);
        guard++;
      end
      if (guard >= 20) begin
        checks++; errors++;
        $display("FAIL ready_timeout: ready low for %0d cycles, required high", guard);
      end
      if (i == n_words - 1) last_cyc = cyc;
      @(posedge clk_i);
    end
  endtask

  task automatic wait_results(input int total);
    int g = 0;
    @(negedge clk_i);
    hash_valid_i = 1'b0;
    target_we_i  = 1'b0;
    hash_last_i  = 1'b0;
    while (res_n < total && g < 40) begin
      @(negedge clk_i);
      g++;
    end
    @(negedge clk_i);
    checks++;
    if (res_n < total) begin
      errors++;
      $display("FAIL result_timeout: got %0d results, required %0d", res_n, total);
      $fatal(1, "result timeout");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      hash_valid_i = 1'b0;
      target_we_i  = 1'b0;
      hash_last_i  = 1'b0;
    end
  endtask

  task automatic write_target(input logic [3:0] idx, input logic [63:0] word);
    @(negedge clk_i);
    target_we_i = 1'b1; target_idx_i = idx; target_word_i = word;
    @(negedge clk_i);
    target_we_i = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) tgt_model[i] = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; hash_valid_i = 0; hash_word_i = '0; hash_last_i = 0;
    nonce_i = '0; target_we_i = 0; target_idx_i = '0; target_word_i = '0;
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
    threshold_i = 11'd10;
`endif
    clear_model();
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    checks++; if (hash_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", hash_ready_o); end
    checks++; if (best_score_o !== 11'd2047) begin errors++; $display("FAIL reset_best: got %0d want 2047", best_score_o); end
    checks++; if (hashes_scored_o !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", hashes_scored_o); end
    checks++; if (protocol_error_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", protocol_error_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", result_valid_o); end
    checks++; if (score_o !== 11'd0 || best_nonce_o !== 64'd0) begin errors++; $display("FAIL reset_regs: score %0d best_nonce %0d want 0 0", score_o, best_nonce_o); end
  endtask

  task automatic test_basic();
    int n0 = res_n;
    int rl0 = ready_low;
    for (int i = 0; i < 16; i++) hw[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    send_hash(64'd5, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 1);
    checks++; if (res_cyc[n0] - last_cyc != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", res_cyc[n0] - last_cyc); end
    checks++; if (res_score[n0] !== 11'd1024) begin errors++; $display("FAIL basic_score: got %0d want 1024", res_score[n0]); end
    checks++; if (res_nonce[n0] !== 64'd5) begin errors++; $display("FAIL basic_nonce: got %0d want 5", res_nonce[n0]); end
    checks++; if (res_bu[n0] !== 1'b1) begin errors++; $display("FAIL basic_best_update: got %b want 1", res_bu[n0]); end
    checks++; if (best_score_o !== 11'd1024 || best_nonce_o !== 64'd5) begin errors++; $display("FAIL basic_best: got %0d/%0d want 1024/5", best_score_o, best_nonce_o); end
    checks++; if (hashes_scored_o !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", hashes_scored_o); end
    checks++; if (ready_low - rl0 != 2) begin errors++; $display("FAIL basic_ready_low: got %0d want 2", ready_low - rl0); end
  endtask

  task automatic test_back_to_back();
    int n0 = res_n;
    int rl0 = ready_low;
    for (int i = 0; i < 16; i++) hw[i] = '0;
    hw[0] = 64'h0F;
    send_hash(64'd6, -1, 0, -1, 4'd0, 64'd0, 0);
    send_hash(64'd7, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 2);
    checks++; if (res_score[n0] !== 11'd4 || res_nonce[n0] !== 64'd6 || res_bu[n0] !== 1'b1) begin errors++; $display("FAIL b2b_first: got %0d/%0d/%b want 4/6/1", res_score[n0], res_nonce[n0], res_bu[n0]); end
    checks++; if (res_score[n0+1] !== 11'd4 || res_nonce[n0+1] !== 64'd7 || res_bu[n0+1] !== 1'b0) begin errors++; $display("FAIL b2b_tie: got %0d/%0d/%b want 4/7/0", res_score[n0+1], res_nonce[n0+1], res_bu[n0+1]); end
    checks++; if (best_score_o !== 11'd4 || best_nonce_o !== 64'd6) begin errors++; $display("FAIL b2b_best: got %0d/%0d want 4/6", best_score_o, best_nonce_o); end
    checks++; if (hashes_scored_o !== 32'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", hashes_scored_o); end
    checks++; if (res_cyc[n0+1] - res_cyc[n0] != 18) begin errors++; $display("FAIL b2b_spacing: got %0d want 18", res_cyc[n0+1] - res_cyc[n0]); end
    checks++; if (ready_low - rl0 != 4) begin errors++; $display("FAIL b2b_ready_low: got %0d want 4", ready_low - rl0); end
  endtask

  task automatic test_framing();
    int n0 = res_n;
    for (int i = 0; i < 16; i++) hw[i] = '0;
    send_hash(64'd8, 9, 0, -1, 4'd0, 64'd0, 0);
    idle(8);
    checks++; if (protocol_error_o !== 1'b1) begin errors++; $display("FAIL frame_early_perr: got %b want 1", protocol_error_o); end
    checks++; if (res_n != n0 || hashes_scored_o !== 32'd3) begin errors++; $display("FAIL frame_early_drop: results %0d count %0d want %0d 3", res_n, hashes_scored_o, n0); end
    send_hash(64'd8, 16, 0, -1, 4'd0, 64'd0, 0);
    idle(8);
    checks++; if (res_n != n0 || hashes_scored_o !== 32'd3 || hash_ready_o !== 1'b1) begin errors++; $display("FAIL frame_nolast_drop: results %0d count %0d ready %b want %0d 3 1", res_n, hashes_scored_o, hash_ready_o, n0); end
    hw[0] = 64'h3;
    send_hash(64'd9, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 1);
    checks++; if (res_score[n0] !== 11'd2 || res_nonce[n0] !== 64'd9) begin errors++; $display("FAIL frame_recover: got %0d/%0d want 2/9", res_score[n0], res_nonce[n0]); end
    checks++; if (hashes_scored_o !== 32'd4 || protocol_error_o !== 1'b1) begin errors++; $display("FAIL frame_recover_state: count %0d perr %b want 4 1", hashes_scored_o, protocol_error_o); end
  endtask

  task automatic test_target_write();
    int n0 = res_n;
    for (int i = 0; i < 16; i++) hw[i] = '0;
    send_hash(64'd10, -1, 0, 5, 4'd3, 64'hFF, 0);
    wait_results(n0 + 1);
    checks++; if (res_score[n0] !== 11'd0) begin errors++; $display("FAIL tgt_midframe_ignored: got %0d want 0", res_score[n0]); end
    checks++; if (best_score_o !== 11'd0 || best_nonce_o !== 64'd10) begin errors++; $display("FAIL tgt_best_before: got %0d/%0d want 0/10", best_score_o, best_nonce_o); end
    write_target(4'd3, 64'hFF);
    tgt_model[3] = 64'hFF;
    @(negedge clk_i);
    checks++; if (best_score_o !== 11'd2047 || best_nonce_o !== 64'd0) begin errors++; $display("FAIL tgt_idle_best_reset: got %0d/%0d want 2047/0", best_score_o, best_nonce_o); end
    send_hash(64'd11, -1, 0, 0, 4'd0, 64'hF0, 0);
    tgt_model[0] = 64'hF0;
    wait_results(n0 + 2);
    checks++; if (res_score[n0+1] !== 11'(exp_score()) || res_score[n0+1] !== 11'd12) begin errors++; $display("FAIL tgt_same_cycle: got %0d want 12", res_score[n0+1]); end
    checks++; if (best_score_o !== 11'd12 || best_nonce_o !== 64'd11 || res_bu[n0+1] !== 1'b1) begin errors++; $display("FAIL tgt_best_after: got %0d/%0d/%b want 12/11/1", best_score_o, best_nonce_o, res_bu[n0+1]); end
  endtask

  task automatic test_gaps();
    int n0;
    for (int k = 0; k < 3; k++) begin
      n0 = res_n;
      for (int i = 0; i < 16; i++) hw[i] = {$urandom, $urandom};
      send_hash(64'd20 + 64'(k), -1, 3, -1, 4'd0, 64'd0, 0);
      wait_results(n0 + 1);
      checks++; if (res_score[n0] !== 11'(exp_score())) begin errors++; $display("FAIL gaps_score_%0d: got %0d want %0d", k, res_score[n0], exp_score()); end
    end
  endtask

  task automatic test_reset_midframe();
    int n0 = res_n;
    for (int i = 0; i < 16; i++) hw[i] = 64'h1;
    send_hash(64'd29, -1, 0, -1, 4'd0, 64'd0, 5);
    @(negedge clk_i);
    rst_i = 1'b1; hash_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_model();
    idle(6);
    checks++; if (res_n != n0) begin errors++; $display("FAIL rst_mid_no_result: got %0d results want %0d", res_n, n0); end
    checks++; if (hashes_scored_o !== 32'd0 || best_score_o !== 11'd2047 || protocol_error_o !== 1'b0 || best_nonce_o !== 64'd0) begin errors++; $display("FAIL rst_mid_state: count %0d best %0d perr %b bn %0d want 0 2047 0 0", hashes_scored_o, best_score_o, protocol_error_o, best_nonce_o); end
    for (int i = 0; i < 16; i++) hw[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    send_hash(64'd30, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 1);
    checks++; if (res_score[n0] !== 11'd1024 || res_nonce[n0] !== 64'd30 || hashes_scored_o !== 32'd1) begin errors++; $display("FAIL rst_mid_after: got %0d/%0d count %0d want 1024/30 1", res_score[n0], res_nonce[n0], hashes_scored_o); end
  endtask

`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
  task automatic test_threshold();
    int n0 = res_n;
    threshold_i = 11'd10;
    for (int i = 0; i < 16; i++) hw[i] = '0;
    hw[0] = 64'hF_FFFF;
    send_hash(64'd40, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 1);
    checks++; if (res_score[n0] !== 11'd20 || hit_o !== 1'b0) begin errors++; $display("FAIL thr_20: score %0d hit %b want 20 0", res_score[n0], hit_o); end
    hw[0] = 64'hFF;
    send_hash(64'd41, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 2);
    checks++; if (hit_o !== 1'b1 || hit_nonce_o !== 64'd41) begin errors++; $display("FAIL thr_8: hit %b nonce %0d want 1 41", hit_o, hit_nonce_o); end
    hw[0] = 64'h1F;
    send_hash(64'd42, -1, 0, -1, 4'd0, 64'd0, 0);
    wait_results(n0 + 3);
    checks++; if (hit_o !== 1'b1 || hit_nonce_o !== 64'd41) begin errors++; $display("FAIL thr_5: hit %b nonce %0d want 1 41", hit_o, hit_nonce_o); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_framing();
    test_target_write();
    test_gaps();
    test_reset_midframe();
`ifdef HASH_RESULT_SCORER_THRESHOLD_EN
    test_threshold();
`endif
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_result_scorer.md
Name: hash_result_scorer

Overview:
- Consumer at the output end of the word-serial Skein hash engine.
- Receives each finished 1024-bit hash as 16 x 64-bit words over a valid/ready handshake, together with the candidate nonce that produced it.
- Computes the Hamming distance of each hash to a stored 1024-bit target.
- Tracks the best (lowest) score and its nonce, and reports every result.

Parameters:
WORD_W, 64, hash word width in bits
WORDS, 16, words per hash (word index is 4 bits)
NONCE_W, 64, candidate nonce width
SCORE_W, 11, score width (covers 0..1024)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
hash_valid_i  in  1  hash word present
hash_ready_o  out  1  scorer accepts a word this cycle
hash_word_i  in  WORD_W  hash word; word 0 arrives first
hash_last_i  in  1  marks word 15 of a hash
nonce_i  in  NONCE_W  candidate nonce; sampled on the word-0 beat
target_we_i  in  1  target word write strobe
target_idx_i  in  4  target word index
target_word_i  in  WORD_W  target word data
result_valid_o  out  1  one-cycle pulse: score_o/result_nonce_o valid
score_o  out  SCORE_W  score of the last completed hash
result_nonce_o  out  NONCE_W  nonce of the last completed hash
best_score_o  out  SCORE_W  lowest score since reset or last target write
best_nonce_o  out  NONCE_W  nonce of the best score
best_update_o  out  1  pulse coincident with result_valid_o when best improved
hashes_scored_o  out  32  completed-hash counter
protocol_error_o  out  1  sticky framing-error flag

Behaviour:
- Beat = hash_valid_i & hash_ready_o at a rising edge.
- Reset values:
  - hash_ready_o=1, result_valid_o=0, best_update_o=0.
  - score_o=0, result_nonce_o=0, best_nonce_o=0.
  - best_score_o=all ones (2047), hashes_scored_o=0, protocol_error_o=0.
  - word index=0, accumulator=0, target=0.
- FSM states:
  - ACCEPT: hash_ready_o=1. Each beat registers popcount(hash_word_i XOR target[idx]) into a stage register and increments idx. Beat with idx=15 and hash_last_i=1 -> DRAIN1.
  - DRAIN1: ready=0. Accumulator adds the final stage value -> DRAIN2.
  - DRAIN2: ready=0. Score registered to score_o; result_valid_o pulses next cycle -> ACCEPT.
- Pipeline:
  - The accumulator adds the stage register one cycle after each beat.
  - The accumulator clears when the word-0 beat's stage value is loaded.
- Latency:
  - result_valid_o is high in the 3rd cycle after the cycle in which word 15 is accepted.
  - hash_ready_o is low for exactly 2 cycles per hash.
  - Word 0 of the next hash may be accepted in the result_valid_o cycle.
- Gaps: any number of idle cycles between beats is allowed; the score is unaffected.
- Best tracking:
  - On result, if score < best_score_o (strict), load best_score_o/best_nonce_o and pulse best_update_o.
  - Ties keep the earlier nonce.
  - hashes_scored_o increments per result and wraps 0xFFFFFFFF->0.
- Framing errors: hash_last_i=1 on a beat with idx!=15, or hash_last_i=0 on the idx=15 beat.
  - protocol_error_o sets and stays set until reset.
  - The frame is discarded: idx->0, accumulator cleared, no result, counter unchanged.
  - FSM stays in ACCEPT.
- Target writes:
  - Honoured only when in ACCEPT with idx=0; otherwise ignored, with no side effect.
  - An honoured write resets best_score_o to 2047 and best_nonce_o to 0.
  - A target write and a word-0 beat in the same cycle: the write lands first and the beat uses the new target word.
- Reset mid-frame: partial hash discarded, all state returns to reset values, no result emitted.
- Score is at most 1024 and never saturates.

Optional Feature:
Macro HASH_RESULT_SCORER_THRESHOLD_EN.
- Defined:
  - Adds input threshold_i (SCORE_W) and output hit_o (1).
  - hit_o sets sticky on any result with score <= threshold_i; it clears on reset or an honoured target write.
  - hit_nonce_o (NONCE_W) captures the first hitting nonce.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset -> hash_ready_o=1, best_score_o=2047, hashes_scored_o=0, protocol_error_o=0, result_valid_o=0.
- Target all zero; hash of 16 words 0xFFFFFFFFFFFFFFFF, nonce 5, back-to-back beats -> result_valid_o in 3rd cycle after the last beat, score_o=1024, best 1024/nonce 5, best_update_o=1, count=1.
- Then word0=0x0F, others 0, nonce 6 -> score 4, best 4/nonce 6. Repeat with nonce 7 -> score 4, best_update_o=0, best_nonce_o stays 6, count=3.
- hash_last_i asserted on beat 9 -> protocol_error_o=1, no result_valid_o, count unchanged. Next well-formed hash scores correctly.
- Target word 3 = 0xFF written mid-frame -> ignored, score uses the old target. Same write while idle -> best_score_o=2047. Random 0-3 cycle valid gaps -> score equals the software popcount.
- Threshold feature: threshold_i=10, scores 20, 8, 5 -> hit_o rises on the 8 and hit_nonce_o holds the nonce for 8.
